// File: rtl/ctrl_arb_pkg.sv
// Shared constants and types for the Sprint1 control-source arbiter.
// Optional feature macro: CTRL_ARB_ROUNDROBIN_EN (see ctrl_arb_pick).
package ctrl_arb_pkg;

    localparam int unsigned CTL_RIGHT  = 0;
    localparam int unsigned CTL_LEFT   = 1;
    localparam int unsigned CTL_GAS    = 2;
    localparam int unsigned CTL_GEARUP = 3;
    localparam int unsigned CTL_GEARDN = 4;
    localparam int unsigned CTL_START  = 5;
    localparam int unsigned CTL_COIN   = 6;
    localparam int unsigned CTL_W      = 7;

    // Owner index width; supports up to four sources.
    localparam int unsigned IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE,
        OWNED
    } arb_state_t;

endpackage

// File: rtl/ctrl_arb_pick.sv
// Combinational source selector: picks one requesting source, optionally skipping one index.
// CTRL_ARB_ROUNDROBIN_EN: search starts at 'start'; otherwise fixed priority, lowest index first.
module ctrl_arb_pick
    import ctrl_arb_pkg::*;
#(
    parameter int unsigned NSRC = 3
) (
    input  logic [NSRC-1:0]  req,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] base;

`ifdef CTRL_ARB_ROUNDROBIN_EN
    assign base = start;
`else
    logic unused_start;
    assign unused_start = ^start;
    assign base = '0;
`endif

    // Each eligible source gets its rotational distance from base; the smallest distance wins.
    always_comb begin
        int unsigned b;
        int unsigned d;
        int unsigned best_d;
        b      = {{(32 - IDX_W){1'b0}}, base};
        d      = 0;
        best_d = NSRC;
        valid  = 1'b0;
        index  = '0;
        for (int unsigned j = 0; j < NSRC; j++) begin
            d = (j >= b) ? (j - b) : (j + NSRC - b);
            if (req[j] && !(excl_en && (excl == IDX_W'(j))) && (d < best_d)) begin
                best_d = d;
                valid  = 1'b1;
                index  = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ctrl_src_arbiter.sv
// Shares one player control set between NSRC sources; coin/start are merged from all sources.
// Build option CTRL_ARB_ROUNDROBIN_EN selects round-robin instead of fixed-priority grants.
module ctrl_src_arbiter
    import ctrl_arb_pkg::*;
#(
    parameter int unsigned NSRC       = 3,
    parameter int unsigned PRESCALE   = 12000,
    parameter int unsigned IDLE_TICKS = 2000
) (
    input  logic                  clk_sys,
    input  logic                  Reset_n,
    input  logic [NSRC*CTL_W-1:0] src_ctl_i,
    input  logic                  game_active_i,
    output logic [CTL_W-1:0]      ctl_o,
    output logic [IDX_W-1:0]      owner_o,
    output logic                  owner_valid_o,
    output logic                  handover_o
);

    localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDLE_W  = $clog2(IDLE_TICKS + 1);

    arb_state_t        state;
    logic [PRESC_W-1:0] presc;
    logic [IDLE_W-1:0]  idle;
    logic               arm_up;
    logic               arm_dn;

    logic [CTL_W-1:0]   src [NSRC];
    logic [NSRC-1:0]    act;
    logic [CTL_GEARDN:0] own;
    logic               coin_any;
    logic               start_any;
    logic               hold;
    logic               tick;
    logic               timeout;
    logic [PRESC_W-1:0] presc_next;
    logic [IDLE_W-1:0]  idle_next;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   rr_start;
    logic               grant;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        assign src[s] = src_ctl_i[s*CTL_W +: CTL_W];
        assign act[s] = |src[s][CTL_GEARDN:CTL_RIGHT];
    end

`ifdef CTRL_ARB_ROUNDROBIN_EN
    logic [IDX_W-1:0] last;
    assign rr_start = (last == IDX_W'(NSRC - 1)) ? '0 : last + 1'b1;
`else
    assign rr_start = '0;
`endif

    always_comb begin
        coin_any  = 1'b0;
        start_any = 1'b0;
        own       = '0;
        for (int s = 0; s < NSRC; s++) begin
            coin_any  = coin_any | src[s][CTL_COIN];
            start_any = start_any | src[s][CTL_START];
            if (owner_o == IDX_W'(s)) begin
                own = src[s][CTL_GEARDN:CTL_RIGHT];
            end
        end
        // Activity or a running race restarts the whole timeout, prescaler phase included.
        hold       = (|own) | game_active_i;
        tick       = (presc == PRESC_W'(PRESCALE - 1));
        presc_next = (hold || tick) ? '0 : presc + 1'b1;
        if (hold) begin
            idle_next = '0;
        end else if (tick && (idle != IDLE_W'(IDLE_TICKS))) begin
            idle_next = idle + 1'b1;
        end else begin
            idle_next = idle;
        end
        timeout = !hold && (idle_next == IDLE_W'(IDLE_TICKS));
    end

    ctrl_arb_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .req     (act),
        .excl_en (state == OWNED),
        .excl    (owner_o),
        .start   (rr_start),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    assign grant = (state == IDLE) ? pick_valid : (timeout && pick_valid);

    always_ff @(posedge clk_sys) begin
        if (!Reset_n) begin
            state         <= IDLE;
            ctl_o         <= '0;
            owner_o       <= '0;
            owner_valid_o <= 1'b0;
            handover_o    <= 1'b0;
            presc         <= '0;
            idle          <= '0;
            arm_up        <= 1'b0;
            arm_dn        <= 1'b0;
`ifdef CTRL_ARB_ROUNDROBIN_EN
            last          <= IDX_W'(NSRC - 1);
`endif
        end else begin
            handover_o      <= 1'b0;
            ctl_o[CTL_COIN]  <= coin_any;
            ctl_o[CTL_START] <= start_any;
            case (state)
                IDLE: begin
                    ctl_o[CTL_GEARDN:CTL_RIGHT] <= '0;
                end
                OWNED: begin
                    ctl_o[CTL_RIGHT]  <= own[CTL_RIGHT];
                    ctl_o[CTL_LEFT]   <= own[CTL_LEFT];
                    ctl_o[CTL_GAS]    <= own[CTL_GAS];
                    ctl_o[CTL_GEARUP] <= own[CTL_GEARUP] & arm_up;
                    ctl_o[CTL_GEARDN] <= own[CTL_GEARDN] & arm_dn;
                end
                default: begin
                    ctl_o[CTL_GEARDN:CTL_RIGHT] <= '0;
                end
            endcase

            if (grant) begin
                state         <= OWNED;
                owner_o       <= pick_idx;
                owner_valid_o <= 1'b1;
                handover_o    <= 1'b1;
                presc         <= '0;
                idle          <= '0;
                // A gear held through the grant must be released before it can shift.
                arm_up        <= 1'b0;
                arm_dn        <= 1'b0;
`ifdef CTRL_ARB_ROUNDROBIN_EN
                last          <= pick_idx;
`endif
            end else if (state == OWNED) begin
                presc  <= presc_next;
                idle   <= idle_next;
                arm_up <= arm_up | ~own[CTL_GEARUP];
                arm_dn <= arm_dn | ~own[CTL_GEARDN];
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_src_arbiter.sv
// Scoreboard bench for ctrl_src_arbiter with PRESCALE=4, IDLE_TICKS=3 (12-cycle timeout).
module tb_ctrl_src_arbiter;

    localparam int unsigned NSRC       = 3;
    localparam int unsigned PRESCALE   = 4;
    localparam int unsigned IDLE_TICKS = 3;

    localparam logic [6:0] B_NONE  = 7'b0000000;
    localparam logic [6:0] B_RIGHT = 7'b0000001;
    localparam logic [6:0] B_GAS   = 7'b0000100;
    localparam logic [6:0] B_GUP   = 7'b0001000;
    localparam logic [6:0] B_COIN  = 7'b1000000;

    // Observed vector: {handover, owner_valid, owner[1:0], ctl[6:0]}
    localparam logic [10:0] M_ALL = 11'h7FF;
    localparam logic [10:0] M_OWN = 11'h780;

    logic        clk_sys;
    logic        reset_n;
    logic [20:0] src;
    logic        game_active;
    logic [6:0]  ctl;
    logic [1:0]  owner;
    logic        owner_valid;
    logic        handover;

    typedef struct {
        int          cyc;
        string       name;
        logic [10:0] mask;
        logic [10:0] val;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] ho_q[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    ctrl_src_arbiter #(
        .NSRC       (NSRC),
        .PRESCALE   (PRESCALE),
        .IDLE_TICKS (IDLE_TICKS)
    ) dut (
        .clk_sys       (clk_sys),
        .Reset_n       (reset_n),
        .src_ctl_i     (src),
        .game_active_i (game_active),
        .ctl_o         (ctl),
        .owner_o       (owner),
        .owner_valid_o (owner_valid),
        .handover_o    (handover)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [10:0] v(input logic ho, input logic vl, input logic [1:0] ow,
                                      input logic [6:0] c);
        return {ho, vl, ow, c};
    endfunction

    function automatic logic [20:0] pack(input logic [6:0] s0, input logic [6:0] s1,
                                         input logic [6:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic expect_at(input int d, input string nm, input logic [10:0] mask,
                             input logic [10:0] val);
        exp_t e;
        e.cyc  = cyc + d;
        e.name = nm;
        e.mask = mask;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic at_neg(input int t);
        while (cyc < t) @(negedge clk_sys);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk_sys) begin
        logic [10:0] obs;
        exp_t        e;
        logic [1:0]  w;
        #1;
        cyc = cyc + 1;
        obs = {handover, owner_valid, owner, ctl};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.val) & e.mask) != 11'h0) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, obs, e.val, e.mask);
            end
        end
        if (handover) begin
            checks++;
            if (ho_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_handover cyc=%0d got owner=%0d want no handover",
                         cyc, owner);
            end else begin
                w = ho_q.pop_front();
                if (owner !== w || owner_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL handover_owner cyc=%0d got owner=%0d valid=%b want owner=%0d valid=1",
                             cyc, owner, owner_valid, w);
                end
            end
        end
    end

    initial begin
        int m;
        int p;
        reset_n     = 1'b0;
        src         = '0;
        game_active = 1'b0;

        at_neg(2);
        expect_at(1, "reset_state", M_ALL, v(0, 0, 0, B_NONE));

        // Single requester from IDLE.
        at_neg(3);
        reset_n = 1'b1;
        src     = pack(B_NONE, B_RIGHT, B_NONE);
        expect_at(1, "grant_src1", M_ALL, v(1, 1, 1, B_NONE));
        ho_q.push_back(2'd1);
        expect_at(2, "src1_right_out", M_ALL, v(0, 1, 1, B_RIGHT));

        // Reset mid-grant, then simultaneous requesters 0 and 2.
        at_neg(5);
        reset_n = 1'b0;
        src     = '0;
        expect_at(1, "reset_mid_grant1", M_ALL, v(0, 0, 0, B_NONE));
        at_neg(6);
        reset_n = 1'b1;
        src     = pack(B_RIGHT, B_NONE, B_RIGHT);
        expect_at(1, "grant_lowest", M_ALL, v(1, 1, 0, B_NONE));
        ho_q.push_back(2'd0);
        expect_at(2, "src0_right_out", M_ALL, v(0, 1, 0, B_RIGHT));

        // Owner 0 goes idle while source 2 holds gas: handover exactly 12 cycles later.
        at_neg(8);
        src = pack(B_NONE, B_NONE, B_GAS);
        expect_at(4, "hold_tick1", M_OWN, v(0, 1, 0, B_NONE));
        expect_at(8, "hold_tick2", M_OWN, v(0, 1, 0, B_NONE));
        expect_at(11, "no_early_handover", M_OWN, v(0, 1, 0, B_NONE));
        expect_at(12, "timeout_handover", M_ALL, v(1, 1, 2, B_NONE));
        ho_q.push_back(2'd2);
        expect_at(13, "src2_gas_out", M_ALL, v(0, 1, 2, B_GAS));

        // Handover to a source already holding gearup: gear masked until re-pressed.
        at_neg(21);
        src = pack(B_NONE, B_GUP, B_NONE);
        expect_at(1, "owner2_released", M_ALL, v(0, 1, 2, B_NONE));
        expect_at(11, "no_early_handover2", M_OWN, v(0, 1, 2, B_NONE));
        expect_at(12, "handover_to_gear", M_ALL, v(1, 1, 1, B_NONE));
        ho_q.push_back(2'd1);
        expect_at(13, "gear_disarmed_a", M_ALL, v(0, 1, 1, B_NONE));
        expect_at(14, "gear_disarmed_b", M_ALL, v(0, 1, 1, B_NONE));
        at_neg(35);
        src = '0;
        expect_at(1, "gear_released", M_ALL, v(0, 1, 1, B_NONE));
        at_neg(36);
        src = pack(B_NONE, B_GUP, B_NONE);
        expect_at(1, "gear_rearmed", M_ALL, v(0, 1, 1, B_GUP));

        // Race running: no handover despite a long idle owner and another requester.
        at_neg(37);
        game_active = 1'b1;
        src         = pack(B_RIGHT, B_NONE, B_NONE);
        expect_at(1, "game_owner_idle", M_ALL, v(0, 1, 1, B_NONE));
        m = 37 + 10 * PRESCALE * IDLE_TICKS;
        expect_at(m - 37, "game_active_hold", M_OWN, v(0, 1, 1, B_NONE));
        at_neg(m);
        game_active = 1'b0;
        p = m;
        expect_at(11, "post_game_no_early", M_OWN, v(0, 1, 1, B_NONE));
        expect_at(12, "post_game_handover", M_ALL, v(1, 1, 0, B_NONE));
        ho_q.push_back(2'd0);
        expect_at(13, "src0_right_again", M_ALL, v(0, 1, 0, B_RIGHT));

        // Keyboard coin while joystick 0 owns, then reset mid-grant.
        at_neg(p + 13);
        src = pack(B_RIGHT, B_NONE, B_COIN);
        expect_at(1, "coin_merged", M_ALL, v(0, 1, 0, B_COIN | B_RIGHT));
        at_neg(p + 14);
        src = pack(B_RIGHT, B_NONE, B_NONE);
        expect_at(1, "coin_dropped", M_ALL, v(0, 1, 0, B_RIGHT));
        at_neg(p + 15);
        reset_n = 1'b0;
        expect_at(1, "reset_mid_grant2", M_ALL, v(0, 0, 0, B_NONE));
        at_neg(p + 16);
        reset_n = 1'b1;
        src     = '0;
        expect_at(1, "idle_after_reset", M_ALL, v(0, 0, 0, B_NONE));

        at_neg(p + 19);
        checks++;
        if (sb.size() != 0 || ho_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got sb=%0d ho=%0d want 0 0", sb.size(), ho_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
